// File: rtl/reject_sched.sv
// reject_sched: sequencing controller for a 4-lane rejection sampler in the
// Kyber matrix-generation path.
//
// For every polynomial (i,j) of the k x k matrix, the controller does four things.
// It re-seeds the XOF. It pulls 128-bit XOF words one at a time and hands each one
// to the sampler. It waits for the sampler's accept mask and lanes. It then writes
// the accepted lanes, lowest lane first, into the coefficient RAM. This repeats
// until N_COEF coefficients are stored for that polynomial.
//
// Handshake semantics: a transfer on the rnd_* stream happens on a rising clock
// edge where rnd_tvalid and rnd_tready are both high. rnd_tready is high only in
// FETCH. smp_random_valid is a one-cycle strobe with no back-pressure. Only
// smp_tvalid in WAIT_SMP is accepted; the sampler may raise it at any time, and it
// is ignored in every other state.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start, k_dim        start request and rank k (legal 1..K_MAX)
//   busy, done, err     status: running / end pulse / illegal-start pulse
//   xof_init, xof_i/j   XOF re-seed strobe with the polynomial's (row, column)
//   rnd_t*              XOF word stream (valid/ready)
//   smp_random_*        word and strobe to the sampler
//   smp_acc/tdata/tvalid  sampler result: lane accept mask and candidate lanes
//   coef_we/addr/data   coefficient RAM write port
//   state               current FSM state, for observation only
module reject_sched #(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 12,
  parameter int N_COEF    = 256,
  parameter int K_MAX     = 4,
  parameter int ADDR_BITS = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [2:0]                  k_dim,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        xof_init,
  output logic [1:0]                  xof_i,
  output logic [1:0]                  xof_j,
  input  logic                        rnd_tvalid,
  output logic                        rnd_tready,
  input  logic [127:0]                rnd_tdata,
  output logic                        smp_random_valid,
  output logic [127:0]                smp_random_in,
  input  logic [LANES-1:0]            smp_acc,
  input  logic [LANES*CAND_BITS-1:0]  smp_tdata,
  input  logic                        smp_tvalid,
  output logic                        coef_we,
  output logic [ADDR_BITS-1:0]        coef_addr,
  output logic [CAND_BITS-1:0]        coef_data,
  output logic [2:0]                  state
);

  localparam int CNT_W  = $clog2(N_COEF) + 1;
  localparam int POLY_W = $clog2(K_MAX * K_MAX);
  localparam int LSEL_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_XOF_INIT  = 3'd1,
    S_FETCH     = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_SMP  = 3'd4,
    S_WRITE     = 3'd5,
    S_NEXT_POLY = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t state_q, state_nxt;

  logic [2:0]                 k_q;
  logic [2:0]                 i_q;   // one bit wider than xof_i so it can reach k
  logic [2:0]                 j_q;
  logic [POLY_W-1:0]          poly_idx;
  logic [CNT_W-1:0]           coef_cnt;
  logic [LANES-1:0]           mask;
  logic [LANES*CAND_BITS-1:0] lane_buf;
  logic [LSEL_W-1:0]          lane_sel;
  logic [CAND_BITS-1:0]       lane_val;
  logic [LANES-1:0]           mask_rest;
  logic                       k_legal;
  logic                       last_coef;
  logic                       j_wrap;
  logic [2:0]                 i_upd;

  assign state     = state_q;
  assign k_legal   = (k_dim >= 3'd1) && (k_dim <= 3'(K_MAX));
  assign last_coef = (coef_cnt == CNT_W'(N_COEF - 1));
  // Clear the lowest set bit, which is the lane written in this cycle.
  assign mask_rest = mask & (mask - LANES'(1));
  assign j_wrap    = ((j_q + 3'd1) == k_q);
  assign i_upd     = j_wrap ? (i_q + 3'd1) : i_q;

  // Lowest set mask bit wins. The loop runs downward, so the last match is the lowest bit.
  always_comb begin
    lane_sel = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (mask[l]) lane_sel = LSEL_W'(l);
    end
  end

  assign lane_val = lane_buf[lane_sel*CAND_BITS +: CAND_BITS];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt        = state_q;
    busy             = 1'b0;
    done             = 1'b0;
    xof_init         = 1'b0;
    xof_i            = '0;
    xof_j            = '0;
    rnd_tready       = 1'b0;
    smp_random_valid = 1'b0;
    coef_we          = 1'b0;
    coef_addr        = '0;
    coef_data        = '0;
    case (state_q)
      S_IDLE: begin
        if (start && k_legal) state_nxt = S_XOF_INIT;
      end
      S_XOF_INIT: begin
        busy      = 1'b1;
        xof_init  = 1'b1;
        xof_i     = i_q[1:0];
        xof_j     = j_q[1:0];
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy       = 1'b1;
        rnd_tready = 1'b1;
        if (rnd_tvalid) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        busy             = 1'b1;
        smp_random_valid = 1'b1;
        state_nxt        = S_WAIT_SMP;
      end
      S_WAIT_SMP: begin
        busy = 1'b1;
        if (smp_tvalid) state_nxt = (smp_acc == '0) ? S_FETCH : S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        coef_we   = 1'b1;
        coef_data = lane_val;
        coef_addr = ADDR_BITS'(poly_idx) * ADDR_BITS'(N_COEF) + ADDR_BITS'(coef_cnt);
        if (last_coef)              state_nxt = S_NEXT_POLY;
        else if (mask_rest == '0)   state_nxt = S_FETCH;
      end
      S_NEXT_POLY: begin
        busy      = 1'b1;
        state_nxt = (i_upd == k_q) ? S_DONE : S_XOF_INIT;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q           <= '0;
      i_q           <= '0;
      j_q           <= '0;
      poly_idx      <= '0;
      coef_cnt      <= '0;
      mask          <= '0;
      lane_buf      <= '0;
      smp_random_in <= '0;
      err           <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (k_legal) begin
              k_q      <= k_dim;
              i_q      <= '0;
              j_q      <= '0;
              poly_idx <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_XOF_INIT: coef_cnt <= '0;
        S_FETCH: begin
          if (rnd_tvalid) smp_random_in <= rnd_tdata;
        end
        S_WAIT_SMP: begin
          if (smp_tvalid) begin
            mask     <= smp_acc;
            lane_buf <= smp_tdata;
          end
        end
        S_WRITE: begin
          coef_cnt <= coef_cnt + CNT_W'(1);
          // A full polynomial drops whatever lanes are still pending.
          mask     <= last_coef ? '0 : mask_rest;
        end
        S_NEXT_POLY: begin
          poly_idx <= poly_idx + POLY_W'(1);
          j_q      <= j_wrap ? 3'd0 : (j_q + 3'd1);
          i_q      <= i_upd;
        end
        default: ;
      endcase
    end
  end

endmodule
